// File: rtl/wb_stage.sv
// +-----------------------------------------------------------------------------+
// | Module   : wb_stage                                                          |
// | Purpose  : Writeback stage merging ALU results and queued LSU load results   |
// |            onto one register-file write port, with rs1/rs2 bypass.           |
// | Revision : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module wb_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_exe_valid_i,
  input  logic [4:0]      alu_exe_rd_i,
  input  logic [XLEN-1:0] alu_exe_rd_value_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_rd_value_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            rs1_bypass_en_o,
  output logic [XLEN-1:0] rs1_bypass_data_o,
  output logic            rs2_bypass_en_o,
  output logic [XLEN-1:0] rs2_bypass_data_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [31:0]     lsu_pending_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [4:0]         r_fifo_rd   [DEPTH];
  logic [XLEN-1:0]    r_fifo_data [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_wb_load;

  logic        w_push;
  logic        w_pop;
  logic        w_alu_win;
  logic [31:0] w_pending;

  assign lsu_ready_o = (r_count != c_cnt_w'(DEPTH));
  // Loads to x0 complete the handshake but never occupy a slot.
  assign w_push      = lsu_valid_i & lsu_ready_o & (lsu_rd_i != 5'd0);
  assign w_alu_win   = alu_exe_valid_i & (alu_exe_rd_i != 5'd0);
  assign w_pop       = ~w_alu_win & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= lsu_rd_i;
      r_fifo_data[r_wr_ptr] <= lsu_rd_value_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      r_wb_load  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (w_alu_win) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= alu_exe_rd_i;
        rf_wdata_o <= alu_exe_rd_value_i;
        r_wb_load  <= 1'b0;
      end else if (w_pop) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= r_fifo_rd[r_rd_ptr];
        rf_wdata_o <= r_fifo_data[r_rd_ptr];
        r_wb_load  <= 1'b1;
      end else begin
        rf_we_o    <= 1'b0;
        r_wb_load  <= 1'b0;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, c_ptr_w'(i) - r_rd_ptr} < r_count) begin
        w_pending[r_fifo_rd[i]] = 1'b1;
      end
    end
    if (r_wb_load) begin
      w_pending[rf_waddr_o] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  assign lsu_pending_o = w_pending;

  logic w_rs1_hit_alu, w_rs1_hit_wb, w_rs2_hit_alu, w_rs2_hit_wb;

  // The ALU value is younger than the write register, so it wins.
  assign w_rs1_hit_alu = alu_exe_valid_i & (alu_exe_rd_i == rs1_addr_i) & (rs1_addr_i != 5'd0);
  assign w_rs1_hit_wb  = rf_we_o & (rf_waddr_o == rs1_addr_i) & (rs1_addr_i != 5'd0);
  assign w_rs2_hit_alu = alu_exe_valid_i & (alu_exe_rd_i == rs2_addr_i) & (rs2_addr_i != 5'd0);
  assign w_rs2_hit_wb  = rf_we_o & (rf_waddr_o == rs2_addr_i) & (rs2_addr_i != 5'd0);

  assign rs1_bypass_en_o   = w_rs1_hit_alu | w_rs1_hit_wb;
  assign rs1_bypass_data_o = w_rs1_hit_alu ? alu_exe_rd_value_i :
                             w_rs1_hit_wb  ? rf_wdata_o : '0;
  assign rs2_bypass_en_o   = w_rs2_hit_alu | w_rs2_hit_wb;
  assign rs2_bypass_data_o = w_rs2_hit_alu ? alu_exe_rd_value_i :
                             w_rs2_hit_wb  ? rf_wdata_o : '0;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_wb_stage                                                       |
// | Purpose  : Randomized self-checking bench for wb_stage against a queue model |
// | Revision : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_wb_stage;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_exe_valid_i;
  logic [4:0]      alu_exe_rd_i;
  logic [XLEN-1:0] alu_exe_rd_value_i;
  logic            lsu_valid_i;
  logic            lsu_ready_o;
  logic [4:0]      lsu_rd_i;
  logic [XLEN-1:0] lsu_rd_value_i;
  logic [4:0]      rs1_addr_i;
  logic [4:0]      rs2_addr_i;
  logic            rs1_bypass_en_o;
  logic [XLEN-1:0] rs1_bypass_data_o;
  logic            rs2_bypass_en_o;
  logic [XLEN-1:0] rs2_bypass_data_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic [31:0]     lsu_pending_o;

  wb_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_exe_valid_i    (alu_exe_valid_i),
    .alu_exe_rd_i       (alu_exe_rd_i),
    .alu_exe_rd_value_i (alu_exe_rd_value_i),
    .lsu_valid_i        (lsu_valid_i),
    .lsu_ready_o        (lsu_ready_o),
    .lsu_rd_i           (lsu_rd_i),
    .lsu_rd_value_i     (lsu_rd_value_i),
    .rs1_addr_i         (rs1_addr_i),
    .rs2_addr_i         (rs2_addr_i),
    .rs1_bypass_en_o    (rs1_bypass_en_o),
    .rs1_bypass_data_o  (rs1_bypass_data_o),
    .rs2_bypass_en_o    (rs2_bypass_en_o),
    .rs2_bypass_data_o  (rs2_bypass_data_o),
    .rf_we_o            (rf_we_o),
    .rf_waddr_o         (rf_waddr_o),
    .rf_wdata_o         (rf_wdata_o),
    .lsu_pending_o      (lsu_pending_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
  } ld_t;

  // Reference model: a plain queue of pending loads plus the write register.
  ld_t             m_q[$];
  logic            m_we;
  logic [4:0]      m_waddr;
  logic [XLEN-1:0] m_wdata;
  logic            m_wb_load;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_we      = 1'b0;
    m_waddr   = '0;
    m_wdata   = '0;
    m_wb_load = 1'b0;
  endtask

  function automatic logic [31:0] exp_pending();
    logic [31:0] p = '0;
    foreach (m_q[i]) p[m_q[i].rd] = 1'b1;
    if (m_wb_load) p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic [XLEN:0] exp_bypass(input logic [4:0] rs);
    if (rs == 0) return '0;
    if (alu_exe_valid_i && alu_exe_rd_i == rs) return {1'b1, alu_exe_rd_value_i};
    if (m_we && m_waddr == rs) return {1'b1, m_wdata};
    return '0;
  endfunction

  task automatic check_all();
    logic [XLEN:0] b1, b2;
    b1 = exp_bypass(rs1_addr_i);
    b2 = exp_bypass(rs2_addr_i);
    chk("ready",    lsu_ready_o, (m_q.size() < DEPTH));
    chk("pending",  lsu_pending_o, exp_pending());
    chk("rf_we",    rf_we_o, m_we);
    chk("rf_waddr", rf_waddr_o, m_waddr);
    chk("rf_wdata", rf_wdata_o, m_wdata);
    chk("rs1_en",   rs1_bypass_en_o, b1[XLEN]);
    chk("rs1_data", rs1_bypass_data_o, b1[XLEN-1:0]);
    chk("rs2_en",   rs2_bypass_en_o, b2[XLEN]);
    chk("rs2_data", rs2_bypass_data_o, b2[XLEN-1:0]);
  endtask

  // One clock cycle: drive, check against the model, advance model and clock.
  task automatic step(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] aval,
                      input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] lval,
                      input logic [4:0] r1, input logic [4:0] r2, output logic acc);
    ld_t h;
    alu_exe_valid_i    = av;
    alu_exe_rd_i       = ard;
    alu_exe_rd_value_i = aval;
    lsu_valid_i        = lv;
    lsu_rd_i           = lrd;
    lsu_rd_value_i     = lval;
    rs1_addr_i         = r1;
    rs2_addr_i         = r2;
    #1;
    check_all();
    acc = lv && (m_q.size() < DEPTH);
    if (av && ard != 0) begin
      m_we = 1'b1; m_waddr = ard; m_wdata = aval; m_wb_load = 1'b0;
    end else if (m_q.size() != 0) begin
      h = m_q.pop_front();
      m_we = 1'b1; m_waddr = h.rd; m_wdata = h.val; m_wb_load = 1'b1;
    end else begin
      m_we = 1'b0; m_wb_load = 1'b0;
    end
    if (acc && lrd != 0) m_q.push_back({lrd, lval});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic mid_reset();
    lsu_valid_i     = 1'b0;
    alu_exe_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_we",      rf_we_o, 1'b0);
    chk("rst_ready",   lsu_ready_o, 1'b1);
    chk("rst_pending", lsu_pending_o, '0);
    chk("rst_waddr",   rf_waddr_o, '0);
    chk("rst_wdata",   rf_wdata_o, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic a;
    int   nacc;
    logic [4:0] got[$];

    rst_n = 1'b0;
    alu_exe_valid_i = 0; alu_exe_rd_i = 0; alu_exe_rd_value_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_rd_value_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("init_we",      rf_we_o, 1'b0);
    chk("init_ready",   lsu_ready_o, 1'b1);
    chk("init_pending", lsu_pending_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU write to x5 with same-cycle bypass
    alu_exe_valid_i = 1; alu_exe_rd_i = 5; alu_exe_rd_value_i = 64'h1234; rs1_addr_i = 5;
    #1;
    chk("t2_byp_en",   rs1_bypass_en_o, 1'b1);
    chk("t2_byp_data", rs1_bypass_data_o, 64'h1234);
    step(1, 5, 64'h1234, 0, 0, 0, 5, 0, a);
    chk("t2_we",    rf_we_o, 1'b1);
    chk("t2_waddr", rf_waddr_o, 5);
    chk("t2_wdata", rf_wdata_o, 64'h1234);

    // ALU write to x0 is discarded
    alu_exe_valid_i = 1; alu_exe_rd_i = 0; alu_exe_rd_value_i = 64'hFF; rs1_addr_i = 0;
    #1;
    chk("t3_byp_en", rs1_bypass_en_o, 1'b0);
    step(1, 0, 64'hFF, 0, 0, 0, 0, 0, a);
    chk("t3_we", rf_we_o, 1'b0);

    // ALU priority over write register in rs2 bypass
    step(1, 9, 64'hA, 0, 0, 0, 0, 9, a);
    alu_exe_valid_i = 1; alu_exe_rd_i = 9; alu_exe_rd_value_i = 64'hB;
    #1;
    chk("t6_alu", rs2_bypass_data_o, 64'hB);
    alu_exe_valid_i = 0;
    #1;
    chk("t6_wb", rs2_bypass_data_o, 64'hA);
    step(0, 0, 0, 0, 0, 0, 0, 9, a);
    idle(2);

    // ALU starves the FIFO until it fills
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 64'(i), 1, 5'(7 + nacc), 64'(16'h700 + nacc), 0, 0, a);
      if (a) nacc++;
    end
    chk("t4_nacc",    nacc, 4);
    chk("t4_ready",   lsu_ready_o, 1'b0);
    chk("t4_pending", lsu_pending_o, 32'h0000_0780);
    step(0, 0, 0, 1, 11, 64'h70B, 0, 0, a);
    chk("t5_acc0", a, 1'b0);
    if (rf_we_o) got.push_back(rf_waddr_o);
    step(0, 0, 0, 1, 11, 64'h70B, 0, 0, a);
    chk("t5_acc1", a, 1'b1);
    if (rf_we_o) got.push_back(rf_waddr_o);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, a);
      if (rf_we_o) got.push_back(rf_waddr_o);
    end
    chk("t4_nwrites", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("t4_order", (i < got.size()) ? got[i] : 5'd0, 5'(7 + i));

    // Randomized traffic in phases of varying ALU pressure
    for (int blk = 0; blk < 20; blk++) begin
      int alu_pct;
      alu_pct = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        step(($urandom_range(0, 99) < alu_pct), 5'($urandom_range(0, 7)), {$urandom, $urandom},
             $urandom_range(0, 1), 5'($urandom_range(0, 10)), {$urandom, $urandom},
             5'($urandom_range(0, 10)), 5'($urandom_range(0, 10)), a);
      end
      if (blk == 9) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
